// File: rtl/expr_eval_if.sv
// Character stream in, running expression value and sticky flags out.
// master drives the characters; slave (the evaluator) drives the results.
interface expr_eval_if #(parameter int W = 8);
  logic [7:0]   in;
  logic         valid;
  logic [W-1:0] result;
  logic         err;
  logic         ovf;

  modport master (output in, input valid, result, err, ovf);
  modport slave  (input in, output valid, result, err, ovf);
endinterface

// File: rtl/expr_eval.sv
// Evaluates digit (op digit)* with '*' over '+', one ASCII char per clock; results registered, 1-cycle latency.
// No backpressure: a character is consumed every edge, NUL is a no-op, ERR absorbs until clr.
module expr_eval #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       clr,
  expr_eval_if.slave bus
);
  localparam int XW = W + 4;

  typedef enum logic [1:0] {IDLE, OPND, OPER, ERR} state_t;

  state_t         state, state_nx;
  logic [XW-1:0]  sum, sum_nx, term, term_nx;
  logic           pend_mul, pend_mul_nx;
  logic           valid_q, valid_nx;
  logic           err_q, err_nx;
  logic           ovf_q, ovf_nx;
  logic [W-1:0]   result_q, result_nx;

  logic           is_dig, is_add, is_mul, is_nul;
  logic [XW-1:0]  dval, prod, sum_add, term_new, tot;

  // Internal values are kept to W bits; the 4 guard bits only expose overflow.
  function automatic logic [XW-1:0] trunc(input logic [XW-1:0] x);
    return {4'b0, x[W-1:0]};
  endfunction

  function automatic logic over(input logic [XW-1:0] x);
    return |x[XW-1:W];
  endfunction

  always_comb begin
    is_dig   = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_add   = (bus.in == 8'h2B);
    is_mul   = (bus.in == 8'h2A);
    is_nul   = (bus.in == 8'h00);
    dval     = {{W{1'b0}}, bus.in[3:0]};
    prod     = term * dval;
    sum_add  = sum + term;
    term_new = pend_mul ? trunc(prod) : dval;
    tot      = sum + term_new;

    state_nx    = state;
    sum_nx      = sum;
    term_nx     = term;
    pend_mul_nx = pend_mul;
    valid_nx    = valid_q;
    result_nx   = result_q;
    err_nx      = err_q;
    ovf_nx      = ovf_q;

    if (!is_nul) begin
      case (state)
        IDLE: begin
          if (is_dig) begin
            state_nx  = OPND;
            sum_nx    = '0;
            term_nx   = dval;
            valid_nx  = 1'b1;
            result_nx = dval[W-1:0];
          end else begin
            state_nx  = ERR;
            valid_nx  = 1'b0;
            result_nx = '0;
            err_nx    = 1'b1;
          end
        end
        OPND: begin
          if (is_add) begin
            state_nx    = OPER;
            sum_nx      = trunc(sum_add);
            term_nx     = '0;
            pend_mul_nx = 1'b0;
            valid_nx    = 1'b0;
            if (over(sum_add)) ovf_nx = 1'b1;
          end else if (is_mul) begin
            state_nx    = OPER;
            pend_mul_nx = 1'b1;
            valid_nx    = 1'b0;
          end else begin
            state_nx  = ERR;
            valid_nx  = 1'b0;
            result_nx = '0;
            err_nx    = 1'b1;
          end
        end
        OPER: begin
          if (is_dig) begin
            state_nx  = OPND;
            term_nx   = term_new;
            valid_nx  = 1'b1;
            result_nx = tot[W-1:0];
            if ((pend_mul && over(prod)) || over(tot)) ovf_nx = 1'b1;
          end else begin
            state_nx  = ERR;
            valid_nx  = 1'b0;
            result_nx = '0;
            err_nx    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      sum      <= '0;
      term     <= '0;
      pend_mul <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      sum      <= sum_nx;
      term     <= term_nx;
      pend_mul <= pend_mul_nx;
      valid_q  <= valid_nx;
      result_q <= result_nx;
      err_q    <= err_nx;
      ovf_q    <= ovf_nx;
    end
  end

  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_expr_eval.sv
// Drives directed and randomized character streams into expr_eval and compares
// every cycle against a string-history reference evaluator.
module tb_expr_eval;
  localparam int W   = 8;
  localparam int M   = 256;
  localparam int MAX = 255;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  expr_eval_if #(.W(W)) bus ();
  expr_eval #(.W(W)) dut (.clk(clk), .clr(clr), .bus(bus));

  int ncmp = 0;
  int nerr = 0;

  byte unsigned mq[$];
  bit m_valid, m_err, m_ovf;
  int m_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_digit(input byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Re-evaluates the whole accepted text, noting overflow at every partial step.
  function automatic void eval_model(output int val, output bit of);
    int s;
    int t;
    s  = 0;
    t  = 0;
    of = 1'b0;
    for (int i = 0; i < mq.size(); i++) begin
      if (is_digit(mq[i])) begin
        int d;
        d = int'(mq[i]) - 48;
        if (i == 0) t = d;
        else if (mq[i-1] == 8'h2A) begin
          t = t * d;
          if (t > MAX) of = 1'b1;
          t = t % M;
        end else t = d;
        if (s + t > MAX) of = 1'b1;
      end else if (mq[i] == 8'h2B) begin
        if (s + t > MAX) of = 1'b1;
        s = (s + t) % M;
        t = 0;
      end
    end
    val = (s + t) % M;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ovf   = 1'b0;
    m_res   = 0;
  endfunction

  function automatic void model_step(input byte unsigned c);
    bit dig, op, last_dig, legal, of;
    int v;
    if (c == 8'h00 || m_err) return;
    dig      = is_digit(c);
    op       = (c == 8'h2B) || (c == 8'h2A);
    last_dig = (mq.size() > 0) && is_digit(mq[mq.size()-1]);
    legal    = dig ? !last_dig : (op && last_dig);
    if (!legal) begin
      m_err   = 1'b1;
      m_valid = 1'b0;
      m_res   = 0;
      return;
    end
    mq.push_back(c);
    eval_model(v, of);
    if (of) m_ovf = 1'b1;
    if (dig) begin
      m_valid = 1'b1;
      m_res   = v;
    end else m_valid = 1'b0;
  endfunction

  task automatic send(input byte unsigned c);
    @(negedge clk);
    bus.in = c;
    @(posedge clk);
    #1;
    model_step(c);
    check("valid",  32'(bus.valid),  32'(m_valid));
    check("result", 32'(bus.result), 32'(m_res));
    check("err",    32'(bus.err),    32'(m_err));
    check("ovf",    32'(bus.ovf),    32'(m_ovf));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Short clr pulse between edges; outputs must drop immediately.
  task automatic pulse_clr();
    #1 clr = 1'b1;
    #1;
    check("clr_valid",  32'(bus.valid),  32'd0);
    check("clr_result", 32'(bus.result), 32'd0);
    check("clr_err",    32'(bus.err),    32'd0);
    check("clr_ovf",    32'(bus.ovf),    32'd0);
    #1 clr = 1'b0;
    model_reset();
  endtask

  function automatic byte unsigned rand_char();
    int r;
    bit want_dig;
    r        = int'($urandom_range(0, 99));
    want_dig = !((mq.size() > 0) && is_digit(mq[mq.size()-1]));
    if (r < 85) begin
      if (want_dig) return 8'(8'h30 + $urandom_range(0, 9));
      return ($urandom_range(0, 1) == 0) ? 8'h2B : 8'h2A;
    end
    if (r < 90) return 8'h00;
    if (r < 94) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 97) return ($urandom_range(0, 1) == 0) ? 8'h2B : 8'h2A;
    return 8'($urandom_range(8'h3A, 8'h7F));
  endfunction

  initial begin
    clr    = 1'b1;
    bus.in = 8'h00;
    model_reset();
    #3;
    check("rst_valid",  32'(bus.valid),  32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_ovf",    32'(bus.ovf),    32'd0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 10; i++) send(8'h00);
    send_str("6+9+4");
    check("sum19", 32'(bus.result), 32'd19);

    send_str("6+9+");
    pulse_clr();
    send_str("6*6");
    check("prod36", 32'(bus.result), 32'd36);

    pulse_clr();
    send_str("2+3*4");
    check("prec14", 32'(bus.result), 32'd14);
    send_str("+1");
    check("prec15", 32'(bus.result), 32'd15);

    pulse_clr();
    send_str("9*9");
    check("ovf_before", 32'(bus.ovf), 32'd0);
    send_str("*9");
    check("wrap217", 32'(bus.result), 32'd217);
    check("ovf_set",  32'(bus.ovf),    32'd1);
    send_str("+1");
    check("ovf_sticky", 32'(bus.ovf), 32'd1);

    pulse_clr();
    send_str("+");
    check("idle_op_err", 32'(bus.err), 32'd1);
    send_str("5");
    check("err_absorb_valid", 32'(bus.valid), 32'd0);

    pulse_clr();
    send_str("47");
    check("two_digit_err", 32'(bus.err), 32'd1);
    pulse_clr();
    send_str("4*a");
    check("ill_err", 32'(bus.err), 32'd1);
    pulse_clr();
    send_str("4");
    send(8'h00);
    check("nul_hold", 32'(bus.result), 32'd4);
    send_str("+");
    check("nul_then_op", 32'(bus.err), 32'd0);

    for (int n = 0; n < 150; n++) begin
      int len;
      pulse_clr();
      len = int'($urandom_range(1, 24));
      for (int k = 0; k < len; k++) send(rand_char());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream consumer of the ASCII character stream fed to the expression recognizer.
- Accepts one ASCII character per clock on the same in[7:0] bus and evaluates expressions of the form digit (op digit)*.
  - Operands: single decimal digits '0'..'9'.
  - Operators: '+' and '*'.
  - '*' binds tighter than '+'.
- Publishes the running value of the expression after every operand, plus sticky error and overflow flags.

Parameters:
- W, 8, result width in bits; all arithmetic is modulo 2^W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- in  input  8  ASCII character, sampled every rising edge of clk.
- valid  output  1  high when the characters so far form a complete expression (last accepted char was a digit).
- result  output  W  value of the expression so far, modulo 2^W; meaningful only when valid=1.
- err  output  1  sticky: an illegal character or an illegal sequence was received.
- ovf  output  1  sticky: some intermediate or final value exceeded 2^W-1.

Behaviour:
- Single clock (clk); reset clr is asynchronous and active-high.
- Reset values: state=IDLE, sum=0, term=0, valid=0, result=0, err=0, ovf=0.
- Character classes:
  - DIG = 8'h30..8'h39 (value d = in-8'h30).
  - ADD = 8'h2B ('+').
  - MUL = 8'h2A ('*').
  - NUL = 8'h00, ignored in every state: no change to anything.
  - Anything else is ILL.
- Internal registers:
  - sum (W+4 bits): total of completed product terms.
  - term (W+4 bits): current product term.
  - pend: pending operator, ADD or MUL.
- States and transitions (taken on the edge that samples in):
  - IDLE: DIG -> OPND with sum=0, term=d. ADD/MUL/ILL -> ERR.
  - OPND (last char a digit):
    - ADD -> OPER with sum=sum+term, term=0, pend=ADD.
    - MUL -> OPER with pend=MUL.
    - DIG/ILL -> ERR. Multi-digit operands are illegal.
  - OPER (last char an operator):
    - DIG -> OPND; term = d if pend=ADD, term = term*d if pend=MUL.
    - ADD/MUL/ILL -> ERR.
  - ERR: absorbing; only clr leaves it. All characters ignored.
- Outputs are registered and update on the same edge that samples the character, giving 1-cycle latency to visibility.
  - Entering OPND: valid=1, result=low W bits of (sum+term_new).
  - Entering OPER: valid=0; result holds its previous value.
  - Entering ERR: valid=0, result=0, err=1.
- Overflow:
  - ovf is set on the edge where any of term*d, sum+term, or sum+term_new exceeds 2^W-1.
  - ovf stays set until clr.
  - Internal sum/term are truncated to W bits after each update, so wrap is modulo 2^W.
  - Evaluation continues after overflow.
- clr has priority over everything, including the character sampled on the same edge. After clr deasserts, the next edge starts a fresh expression from IDLE.
- A clr pulse mid-expression (between clock edges) discards the partial result. Outputs read 0 from clr assertion onward.

Test Plan:
- in=0 for 10 cycles, then "6","+","9","+","4" one per cycle -> valid pattern 1,0,1,0,1; result 6,-,15,-,19; err=0, ovf=0.
- "6","+","9","+" then clr pulse 2ns mid-cycle, then "6","*","6" -> outputs 0 during clr; afterwards result 6 then 36, valid=1, err=0.
- "2","+","3","*","4" -> result 2, 5 (after '3'), 14 (precedence); then "+","1" -> 15.
- W=8: "9","*","9","*","9" -> result 9, 81, 217 (729 mod 256); ovf rises on the last digit edge and stays 1.
- "+" from IDLE -> err=1, valid=0, result=0; subsequent "5" ignored (err stays 1, valid stays 0) until clr.
- "4","7" -> err on second digit; "4","*","a" -> err on 'a'; NUL between "4" and "+" leaves state unchanged, with result still 4.
